// File: rtl/alu_flag_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_flag_pkg
//  Description : Shared types for the ALU flag consumer: condition-code
//                encoding, flag bundle layout, query FSM states and the
//                default depth of the pending-update tracker.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_flag_pkg;

    // Default number of flag-setting ALU ops that may be in flight at once.
    localparam int c_MAX_PEND = 4;

    // Architectural flag bundle, packed MSB-first as {c,z,s,o}.
    typedef struct packed {
        logic c;
        logic z;
        logic s;
        logic o;
    } flags_t;

    // Branch condition selector.
    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    // Query handshake FSM.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage : alu_flag_pkg
`default_nettype wire

// File: rtl/alu_cond_eval.sv
`default_nettype none
// ============================================================================
//  Module      : alu_cond_eval
//  Description : Purely combinational branch-condition evaluator. Maps a
//                condition code and a flag bundle to a taken/not-taken bit.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_cond_eval
    import alu_flag_pkg::*;
(
    input  flags_t flags,
    input  cond_e  code,
    output logic   taken
);

    // Signed comparisons reduce to whether sign agrees with overflow.
    logic w_s_eq_o;
    assign w_s_eq_o = (flags.s == flags.o);

    // Condition table lookup.
    always_comb begin
        taken = 1'b0;
        case (code)
            COND_EQ: taken = flags.z;
            COND_NE: taken = ~flags.z;
            COND_CS: taken = flags.c;
            COND_CC: taken = ~flags.c;
            COND_MI: taken = flags.s;
            COND_PL: taken = ~flags.s;
            COND_VS: taken = flags.o;
            COND_VC: taken = ~flags.o;
            COND_HI: taken = flags.c & ~flags.z;
            COND_LS: taken = ~flags.c | flags.z;
            COND_GE: taken = w_s_eq_o;
            COND_LT: taken = ~w_s_eq_o;
            COND_GT: taken = ~flags.z & w_s_eq_o;
            COND_LE: taken = flags.z | ~w_s_eq_o;
            COND_AL: taken = 1'b1;
            COND_NV: taken = 1'b0;
            default: taken = 1'b0;
        endcase
    end

endmodule : alu_cond_eval
`default_nettype wire

// File: rtl/alu_flag_cond_unit.sv
`default_nettype none
// ============================================================================
//  Module      : alu_flag_cond_unit
//  Description : Consumer end of the ALU flag interface. Holds the
//                architectural {c,z,s,o} register and a sticky overflow bit,
//                tracks flag-setting ops still in flight, and answers branch
//                condition queries over a valid/ready handshake without ever
//                evaluating against flags that are about to be overwritten.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_flag_cond_unit
    import alu_flag_pkg::*;
#(
    parameter int MAX_PEND = c_MAX_PEND,
    parameter int CNT_W    = $clog2(MAX_PEND + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pend_inc,
    input  logic             flag_valid,
    input  logic             c_flag,
    input  logic             z_flag,
    input  logic             s_flag,
    input  logic             o_flag,
    input  logic             clr_sticky,
    input  logic             cond_valid,
    input  logic [3:0]       cond_code,
    output logic             cond_ready,
    output logic             resp_valid,
    output logic             resp_taken,
    output logic [3:0]       flags_q,
    output logic             so_sticky,
    output logic [CNT_W-1:0] pend_cnt,
    output logic             pend_full,
    output logic             err_ovf,
    output logic             err_unf
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = CNT_W'(MAX_PEND);
    localparam logic [CNT_W-1:0] c_CNT_ONE = CNT_W'(1);

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    state_e           r_state;
    flags_t           r_flags;
    logic             r_so_sticky;
    logic [CNT_W-1:0] r_cnt;
    logic             r_err_ovf;
    logic             r_err_unf;
    cond_e            r_code;
    logic             r_taken;

    // ------------------------------------------------------------------------
    // Combinational signals
    // ------------------------------------------------------------------------
    flags_t           w_in_flags;
    flags_t           w_fwd;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_set_ovf;
    logic             w_set_unf;
    logic             w_eff_zero;
    state_e           w_state_nxt;
    cond_e            w_eval_code;
    logic             w_eval_taken;
    logic             w_load_taken;
    logic             w_capture;

    // Bundle the incoming flags and forward them past the register when a
    // result lands in the same cycle, so a query sees the freshest values.
    always_comb begin
        w_in_flags.c = c_flag;
        w_in_flags.z = z_flag;
        w_in_flags.s = s_flag;
        w_in_flags.o = o_flag;
        w_fwd        = flag_valid ? w_in_flags : r_flags;
    end

    // Pending-op counter next value, saturating at both ends and flagging
    // protocol errors instead of wrapping.
    always_comb begin
        w_cnt_nxt = r_cnt;
        w_set_ovf = 1'b0;
        w_set_unf = 1'b0;
        case ({pend_inc, flag_valid})
            2'b10: begin
                if (r_cnt == c_CNT_MAX) begin
                    w_set_ovf = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            2'b01: begin
                if (r_cnt == '0) begin
                    w_set_unf = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - c_CNT_ONE;
                end
            end
            default: w_cnt_nxt = r_cnt;
        endcase
    end

    // A query may only be evaluated once nothing older is still in flight.
    // A pend_inc arriving alongside the query counts as older, which falls
    // out naturally from looking at the post-update count. An underflowing
    // flag_valid still delivers fresh flags, so it is treated as settled.
    assign w_eff_zero = (w_cnt_nxt == '0);

    // Single evaluator: IDLE looks at the live code, WAIT at the captured one.
    alu_cond_eval u_cond_eval (
        .flags (w_fwd),
        .code  (w_eval_code),
        .taken (w_eval_taken)
    );

    // Query FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Query FSM next-state and datapath control.
    always_comb begin
        w_state_nxt  = r_state;
        w_eval_code  = r_code;
        w_load_taken = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                w_eval_code = cond_e'(cond_code);
                if (cond_valid) begin
                    if (w_eff_zero) begin
                        w_load_taken = 1'b1;
                        w_state_nxt  = RESP;
                    end else begin
                        w_capture    = 1'b1;
                        w_state_nxt  = WAIT;
                    end
                end
            end
            WAIT: begin
                if (w_eff_zero) begin
                    w_load_taken = 1'b1;
                    w_state_nxt  = RESP;
                end
            end
            RESP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Flag register, sticky overflow, pending counter, error bits and the
    // query datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags     <= '0;
            r_so_sticky <= 1'b0;
            r_cnt       <= '0;
            r_err_ovf   <= 1'b0;
            r_err_unf   <= 1'b0;
            r_code      <= COND_EQ;
            r_taken     <= 1'b0;
        end else begin
            if (flag_valid) begin
                r_flags <= w_in_flags;
            end
            // A new overflow beats a simultaneous clear so no event is lost.
            if (flag_valid && o_flag) begin
                r_so_sticky <= 1'b1;
            end else if (clr_sticky) begin
                r_so_sticky <= 1'b0;
            end
            r_cnt <= w_cnt_nxt;
            if (w_set_ovf) begin
                r_err_ovf <= 1'b1;
            end
            if (w_set_unf) begin
                r_err_unf <= 1'b1;
            end
            if (w_capture) begin
                r_code <= cond_e'(cond_code);
            end
            if (w_load_taken) begin
                r_taken <= w_eval_taken;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign cond_ready = (r_state == IDLE);
    assign resp_valid = (r_state == RESP);
    assign resp_taken = r_taken;
    assign flags_q    = r_flags;
    assign so_sticky  = r_so_sticky;
    assign pend_cnt   = r_cnt;
    assign pend_full  = (r_cnt == c_CNT_MAX);
    assign err_ovf    = r_err_ovf;
    assign err_unf    = r_err_unf;

endmodule : alu_flag_cond_unit
`default_nettype wire
